ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Sits between the ps2_keyboard receive FIFO and the display/seven-segment logic.
- Pops scancode bytes through the FIFO's ready/nextdata_n handshake and decodes the set-2 prefixes (E0 extended, F0 break).
- Emits one clean key event per make or break, and keeps a small held-key table so typematic repeats are flagged, not counted.
- Generalises the single-key make/break FSM: rollover depth, counter width, extended keys and repeat detection are all new.

Parameters:
- CNT_W, 8: width of press_count; wraps modulo 2^CNT_W.
- N_HELD, 4: held-key table depth (simultaneously held keys tracked); legal range 1..8.

Ports:
- clk  in  1  system clock, same as ps2_keyboard clk.
- resetn  in  1  asynchronous active-low reset.
- fifo_data  in  8  ps2_keyboard data (head of FIFO).
- fifo_ready  in  1  ps2_keyboard ready; FIFO non-empty.
- fifo_nextdata_n  out  1  active-low pop strobe to ps2_keyboard.
- clr_count  in  1  synchronous clear of press_count.
- evt_valid  out  1  one-cycle key-event strobe.
- evt_code  out  8  scancode of the event (prefixes stripped).
- evt_ext  out  1  event key was E0-prefixed.
- evt_break  out  1  event is a release.
- evt_repeat  out  1  make for a key already held (typematic).
- last_code  out  8  code of the most recent make, held until the next make.
- last_ext  out  1  ext flag of last_code.
- held_count  out  4  number of valid table entries.
- press_count  out  CNT_W  count of new (non-repeat) makes.
- table_full_err  out  1  sticky; set when a new make found the table full.

Behaviour:
- Reset (resetn low, asynchronous):
  - fifo_nextdata_n=1; evt_* outputs=0; last_code=0; last_ext=0; held_count=0; press_count=0; table_full_err=0.
  - Table cleared, pending flags cleared, FSM to S_IDLE.
  - Reset mid-sequence discards any partial prefix. The byte in flight stays in the FIFO if it was not yet popped.
- All outputs are registered.
- FSM states:
  - S_IDLE: when fifo_ready=1, latch byte_q<=fifo_data, drive fifo_nextdata_n<=0, go to S_POP.
  - S_POP: fifo_nextdata_n<=1 (exactly one low cycle per byte), go to S_DECODE. This state also gives the FIFO read pointer one cycle to settle before ready is re-sampled.
  - S_DECODE: classify byte_q, then return to S_IDLE.
    - 0xE0: ext_pend<=1; no event.
    - 0xF0: brk_pend<=1; no event.
    - 0x00, 0xFF, 0xAA, 0xFA, 0xEE, 0xE1: discarded; ext_pend and brk_pend cleared; no event.
    - Any other byte: event. evt_valid=1 on the next cycle with evt_code=byte_q, evt_ext=ext_pend, evt_break=brk_pend. Both pend flags are then cleared.
- Latency and throughput:
  - If fifo_ready is sampled high at edge T: fifo_nextdata_n is low during T+1 and evt_valid is high during T+3.
  - One byte every 3 cycles maximum; back-to-back bytes are not a special case.
- Make (brk_pend=0):
  - Match on {ext, code} with a valid table entry gives evt_repeat=1; press_count, last_code and the table are unchanged.
  - With no match: insert into the lowest-index free slot, press_count+1 (wraps), last_code/last_ext updated, evt_repeat=0.
  - With no match and the table full: table_full_err<=1 and the key is not stored. The event is still emitted, press_count+1, and last_code is updated.
- Break (brk_pend=1): invalidate the matching entry. A break with no matching entry is legal and changes only evt_*. evt_repeat is always 0 on a break.
- F0 and E0 order: E0 F0 xx and F0 E0 xx both decode as ext break.
- held_count updates in the same cycle evt_valid asserts.
- clr_count=1 zeroes press_count next edge. If it coincides with an increment, the clear wins. The table and table_full_err are unaffected; table_full_err clears only on reset.

Decomposition:
- ps2_pkg: byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, and the discard list (00, FF, AA, FA, EE, E1); FSM state enum.
- Sub-module ps2_held_table (parameter N_HELD):
  - Inputs: lookup key {ext, code}, ins, del.
  - Outputs: hit, full, count.
  - Lookup is combinational; update is registered.
- The FSM and counters stay in ps2_key_tracker.

Test Plan:
- Bytes 15, F0 15 through a FIFO model -> two events: (code=15, brk=0, rep=0) then (15, brk=1). press_count=1, held_count goes 1 then 0, last_code=15. Exactly one nextdata_n low cycle per byte; evt_valid 3 cycles after ready.
- Bytes E0 75, E0 F0 75 -> events (75, ext=1, brk=0) then (75, ext=1, brk=1). A plain 75 interleaved is tracked as a distinct entry: held_count reaches 2.
- Typematic: 1C 1C 1C F0 1C -> second and third makes have evt_repeat=1. press_count=1 at the end, held_count=0.
- Rollover with N_HELD=4: makes 15 1D 24 2D 2C -> table_full_err=1 on 2C. press_count=5, held_count=4. F0 2C -> no entry removed, held_count stays 4.
- CNT_W=2: five distinct make/break pairs -> press_count sequence 1,2,3,0,1. clr_count asserted on the same cycle as a make -> press_count=0.
- Bytes E0 then AA -> no event, ext_pend cleared; next 15 gives ext=0. Assert resetn low between F0 and 15 -> the following 15 decodes as a make with all counters at 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 key tracker.
//   PS2_EXT / PS2_BRK : set-2 prefix bytes (extended, break)
//   is_discard()      : bytes that are keyboard status/ack, never keys
//   state_t           : byte-handling FSM states
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  // Error, BAT-ok, ack, echo and pause-prefix bytes carry no key.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hE1: is_discard = 1'b1;
      default:                                  is_discard = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_held_table.sv
// ps2_held_table: small table of currently held keys, keyed by {ext, code}.
//   clk, resetn         : clock, async active-low reset
//   key_ext, key_code   : lookup / update key
//   ins                 : store key in lowest free slot (ignored on hit)
//   del                 : invalidate the entry matching key
//   hit, full           : combinational lookup results
//   count               : registered number of valid entries
module ps2_held_table #(
  parameter int N_HELD = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_ext,
  input  logic [7:0] key_code,
  input  logic       ins,
  input  logic       del,
  output logic       hit,
  output logic       full,
  output logic [3:0] count
);

  logic [N_HELD-1:0] valid_q, valid_d;
  logic [8:0]        key_q [N_HELD];
  logic [8:0]        key_d [N_HELD];
  logic [N_HELD-1:0] match;
  logic [3:0]        count_q, count_d;
  logic              placed;

  always_comb begin
    match = '0;
    for (int i = 0; i < N_HELD; i++) begin
      match[i] = valid_q[i] && (key_q[i] == {key_ext, key_code});
    end
  end

  assign hit   = |match;
  assign full  = &valid_q;
  assign count = count_q;

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    placed  = 1'b0;
    if (del) begin
      valid_d = valid_q & ~match;
    end else if (ins && !hit) begin
      for (int i = 0; i < N_HELD; i++) begin
        if (!valid_q[i] && !placed) begin
          valid_d[i] = 1'b1;
          key_d[i]   = {key_ext, key_code};
          placed     = 1'b1;
        end
      end
    end
    // Count follows the new contents so it moves with the event strobe.
    count_d = '0;
    for (int i = 0; i < N_HELD; i++) begin
      count_d = count_d + {3'b000, valid_d[i]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < N_HELD; i++) key_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      key_q   <= key_d;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: pops set-2 scancode bytes from the ps2_keyboard FIFO,
// strips E0/F0 prefixes and emits one event per make/break, flagging
// typematic repeats via a held-key table.
//   fifo_data/fifo_ready/fifo_nextdata_n : FIFO head, non-empty, pop strobe
//   clr_count                            : sync clear of press_count
//   evt_*                                : one-cycle key event
//   last_code/last_ext                   : most recent make
//   held_count, press_count              : held keys, new makes (wrapping)
//   table_full_err                       : sticky, make lost for lack of slot
//
// state    | meaning
// S_IDLE   | wait for fifo_ready, latch byte, start pop strobe
// S_POP    | end pop strobe, let FIFO pointer settle
// S_DECODE | classify byte, update pend flags / table / counters
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int N_HELD = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_ready,
  output logic             fifo_nextdata_n,
  input  logic             clr_count,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic [7:0]       last_code,
  output logic             last_ext,
  output logic [3:0]       held_count,
  output logic [CNT_W-1:0] press_count,
  output logic             table_full_err
);

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             ext_pend_q, ext_pend_d;
  logic             brk_pend_q, brk_pend_d;
  logic             evt_valid_q, evt_valid_d;
  logic [7:0]       evt_code_q, evt_code_d;
  logic             evt_ext_q, evt_ext_d;
  logic             evt_break_q, evt_break_d;
  logic             evt_repeat_q, evt_repeat_d;
  logic [7:0]       last_code_q, last_code_d;
  logic             last_ext_q, last_ext_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             err_q, err_d;
  logic             tbl_ins, tbl_del, tbl_hit, tbl_full;

  ps2_held_table #(.N_HELD(N_HELD)) u_table (
    .clk      (clk),
    .resetn   (resetn),
    .key_ext  (ext_pend_q),
    .key_code (byte_q),
    .ins      (tbl_ins),
    .del      (tbl_del),
    .hit      (tbl_hit),
    .full     (tbl_full),
    .count    (held_count)
  );

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    nextdata_n_d  = 1'b1;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    evt_valid_d   = 1'b0;
    evt_code_d    = evt_code_q;
    evt_ext_d     = evt_ext_q;
    evt_break_d   = evt_break_q;
    evt_repeat_d  = evt_repeat_q;
    last_code_d   = last_code_q;
    last_ext_d    = last_ext_q;
    press_count_d = press_count_q;
    err_d         = err_q;
    tbl_ins       = 1'b0;
    tbl_del       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_ready) begin
          byte_d       = fifo_data;
          nextdata_n_d = 1'b0;
          state_d      = S_POP;
        end
      end
      S_POP: state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_IDLE;
        if (byte_q == PS2_EXT) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == PS2_BRK) begin
          brk_pend_d = 1'b1;
        end else if (is_discard(byte_q)) begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else begin
          evt_valid_d  = 1'b1;
          evt_code_d   = byte_q;
          evt_ext_d    = ext_pend_q;
          evt_break_d  = brk_pend_q;
          evt_repeat_d = 1'b0;
          ext_pend_d   = 1'b0;
          brk_pend_d   = 1'b0;
          if (brk_pend_q) begin
            tbl_del = 1'b1;
          end else if (tbl_hit) begin
            evt_repeat_d = 1'b1;
          end else begin
            // A new make counts even when the table cannot hold it.
            press_count_d = press_count_q + CNT_W'(1);
            last_code_d   = byte_q;
            last_ext_d    = ext_pend_q;
            if (tbl_full) err_d = 1'b1;
            else          tbl_ins = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_count) press_count_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      byte_q        <= '0;
      nextdata_n_q  <= 1'b1;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= '0;
      evt_ext_q     <= 1'b0;
      evt_break_q   <= 1'b0;
      evt_repeat_q  <= 1'b0;
      last_code_q   <= '0;
      last_ext_q    <= 1'b0;
      press_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      nextdata_n_q  <= nextdata_n_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_ext_q     <= evt_ext_d;
      evt_break_q   <= evt_break_d;
      evt_repeat_q  <= evt_repeat_d;
      last_code_q   <= last_code_d;
      last_ext_q    <= last_ext_d;
      press_count_q <= press_count_d;
      err_q         <= err_d;
    end
  end

  assign fifo_nextdata_n = nextdata_n_q;
  assign evt_valid       = evt_valid_q;
  assign evt_code        = evt_code_q;
  assign evt_ext         = evt_ext_q;
  assign evt_break       = evt_break_q;
  assign evt_repeat      = evt_repeat_q;
  assign last_code       = last_code_q;
  assign last_ext        = last_ext_q;
  assign press_count     = press_count_q;
  assign table_full_err  = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: FIFO model feeding the tracker, a cycle monitor that
// predicts pop timing and event content from the scancode rules, and
// directed plus randomized byte streams.
module tb_ps2_key_tracker;

  localparam int CNT_W  = 2;
  localparam int N_HELD = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [7:0]       fifo_data = 8'h00;
  logic             fifo_ready = 1'b0;
  logic             clr_count = 1'b0;
  logic             fifo_nextdata_n;
  logic             evt_valid, evt_ext, evt_break, evt_repeat;
  logic [7:0]       evt_code, last_code;
  logic             last_ext, table_full_err;
  logic [3:0]       held_count;
  logic [CNT_W-1:0] press_count;

  ps2_key_tracker #(.CNT_W(CNT_W), .N_HELD(N_HELD)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .fifo_data       (fifo_data),
    .fifo_ready      (fifo_ready),
    .fifo_nextdata_n (fifo_nextdata_n),
    .clr_count       (clr_count),
    .evt_valid       (evt_valid),
    .evt_code        (evt_code),
    .evt_ext         (evt_ext),
    .evt_break       (evt_break),
    .evt_repeat      (evt_repeat),
    .last_code       (last_code),
    .last_ext        (last_ext),
    .held_count      (held_count),
    .press_count     (press_count),
    .table_full_err  (table_full_err)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO model: pop on an edge where nextdata_n is low, update at negedge.
  logic [7:0] fifo_q[$];
  int pushed = 0;
  int popped = 0;

  initial begin
    logic pop_req;
    forever begin
      @(posedge clk);
      pop_req = (fifo_nextdata_n === 1'b0);
      @(negedge clk);
      if (pop_req && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        popped++;
      end
      fifo_ready = (fifo_q.size() != 0);
      fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Reference model state.
  typedef struct packed {
    logic [7:0]  b;
    logic [31:0] due;
  } pend_t;

  pend_t            pend_q[$];
  logic [8:0]       m_held[$];
  logic             m_ext, m_brk, m_last_ext, m_err;
  logic [7:0]       m_last;
  logic [CNT_W-1:0] m_press;
  int               cyc = 0;
  int               last_pop = -100;

  initial begin
    forever begin
      logic       exp_pop, ev, e_ext, e_brk, e_rep;
      logic [7:0] b;
      logic [8:0] key;
      int         idx;
      @(posedge clk);
      #1;
      cyc++;
      if (!resetn) begin
        pend_q.delete();
        m_held.delete();
        m_ext = 0; m_brk = 0; m_last = 0; m_last_ext = 0; m_err = 0; m_press = 0;
        last_pop = cyc - 100;
        chk_val("rst_nextdata_n", fifo_nextdata_n, 1);
        chk_val("rst_evt", {evt_valid, evt_ext, evt_break, evt_repeat, evt_code}, 0);
        chk_val("rst_last", {last_ext, last_code}, 0);
        chk_val("rst_counts", {table_full_err, held_count, press_count}, 0);
        continue;
      end

      // Pop expected whenever the tracker is idle (3 cycles since last pop).
      exp_pop = fifo_ready && (cyc - last_pop >= 3);
      chk_val("nextdata_n", fifo_nextdata_n, !exp_pop);
      if (exp_pop) begin
        pend_q.push_back('{b: fifo_data, due: 32'(cyc + 2)});
        last_pop = cyc;
      end

      ev = 0; e_ext = 0; e_brk = 0; e_rep = 0; b = 0;
      if (pend_q.size() > 0 && pend_q[0].due == 32'(cyc)) begin
        b = pend_q[0].b;
        void'(pend_q.pop_front());
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hE1}) begin
          m_ext = 0; m_brk = 0;
        end else begin
          ev = 1; e_ext = m_ext; e_brk = m_brk;
          key = {m_ext, b};
          idx = -1;
          foreach (m_held[i]) if (m_held[i] == key) idx = i;
          if (m_brk) begin
            if (idx >= 0) m_held.delete(idx);
          end else if (idx >= 0) begin
            e_rep = 1;
          end else begin
            m_press = m_press + 1'b1;
            m_last = b; m_last_ext = m_ext;
            if (m_held.size() < N_HELD) m_held.push_back(key);
            else m_err = 1;
          end
          m_ext = 0; m_brk = 0;
        end
      end
      chk_val("evt_valid", evt_valid, ev);
      if (ev) begin
        chk_val("evt_code", evt_code, b);
        chk_val("evt_flags", {evt_ext, evt_break, evt_repeat}, {e_ext, e_brk, e_rep});
      end
      if (clr_count) m_press = 0;
      chk_val("press_count", press_count, m_press);
      chk_val("held_count", held_count, m_held.size());
      chk_val("last_code", {last_ext, last_code}, {m_last_ext, m_last});
      chk_val("table_full_err", table_full_err, m_err);
    end
  end

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
    pushed++;
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_q.size() != 0 || pend_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk_val("drain_in_time", n < 3000, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_pop();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (fifo_nextdata_n !== 1'b0 && n < 100);
    chk_val("pop_seen", fifo_nextdata_n, 0);
  endtask

  logic [7:0] pool[6]     = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h75};
  logic [7:0] discards[6] = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hE1};

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // make / break
    send(8'h15); send(8'hF0); send(8'h15); drain();
    // extended key next to a plain one with the same code
    send(8'hE0); send(8'h75); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75); send(8'hF0); send(8'h75); drain();
    // F0 E0 ordering
    send(8'hE0); send(8'h75); send(8'hF0); send(8'hE0); send(8'h75); drain();
    // typematic
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); drain();
    // rollover past the table depth
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    send(8'hF0); send(8'h2C); drain();
    send(8'hF0); send(8'h15); send(8'hF0); send(8'h1D);
    send(8'hF0); send(8'h24); send(8'hF0); send(8'h2D); drain();
    // clear coinciding with a make
    send(8'h33);
    wait_pop();
    @(negedge clk);
    @(negedge clk); clr_count = 1'b1;
    @(negedge clk); clr_count = 1'b0;
    drain();
    send(8'hF0); send(8'h33); drain();
    // discard byte cancels a pending prefix
    send(8'hE0); send(8'hAA); send(8'h15); send(8'hF0); send(8'h15); drain();
    // reset after a lone break prefix
    send(8'hF0); drain();
    @(negedge clk); resetn = 1'b0;
    repeat (2) @(negedge clk); resetn = 1'b1;
    send(8'h15); drain();
    // reset while a byte is being popped: the byte stays in the FIFO
    send(8'h16);
    wait_pop();
    @(negedge clk); resetn = 1'b0;
    repeat (2) @(negedge clk); resetn = 1'b1;
    drain();

    // randomized stream
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send(discards[$urandom_range(0, 5)]);
      end else begin
        if ($urandom_range(0, 2) == 0) send(8'hE0);
        if (r >= 6) send(8'hF0);
        send(pool[$urandom_range(0, 5)]);
      end
      repeat ($urandom_range(1, 8)) begin
        @(negedge clk);
        clr_count = ($urandom_range(0, 15) == 0);
      end
    end
    @(negedge clk); clr_count = 1'b0;
    drain();

    chk_val("pops_eq_pushes", popped, pushed);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
